// File: rtl/fft_pkg.sv
// Purpose: shared types and helpers for the SDF FFT stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default sample width, complex sample type, and a power-of-two check for depths.
package fft_pkg;

    localparam int SAMPLE_W = 24;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    // True when n is a positive power of two (1, 2, 4, ...).
    function automatic bit is_pow2(input int n);
        return (n >= 1) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/delay_lane.sv
// Purpose: DEPTH-stage shift register with enable and async clear.
// Latency: DEPTH enabled cycles from d to q.
// Backpressure: none; shifts whenever en is high.
// Ports: clk, rst_n (async active-low); en shifts the lane; d enters stage 0;
//        q is the last stage; nz is high when any stage holds a nonzero value.
module delay_lane #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         nz
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

    always_comb begin
        nz = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            nz = nz | (|stage[k]);
        end
    end

endmodule

// File: rtl/sdf_delay_line.sv
// Purpose: complex delay line for an SDF FFT stage, with valid lane, drain and phase counter.
// Latency: exactly DEPTH advances from din to dout; output driven straight from a register.
// Backpressure: none; the consumer must take every sample presented with out_valid=1.
// Ports: clk, rst_n (async active-low); in_valid/din_r/din_i sample in;
//        dout_r/dout_i/out_valid delayed sample out; phase = advances mod 2*DEPTH;
//        busy = line advancing or still holding valid samples.
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(2 * DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] din_r,
    input  logic signed [WIDTH-1:0] din_i,
    output logic signed [WIDTH-1:0] dout_r,
    output logic signed [WIDTH-1:0] dout_i,
    output logic                    out_valid,
    output logic [CW-1:0]           phase,
    output logic                    busy
);

    // Drain counter spans 0..DEPTH inclusive.
    localparam int DCW = $clog2(DEPTH + 1);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sdf_delay_line: DEPTH must be a power of two and at least 1");
    end

    logic             advance;
    logic [DCW-1:0]   drain_cnt;
    logic [WIDTH-1:0] ld_r;
    logic [WIDTH-1:0] ld_i;
    logic             valid_any;
    logic             unused_nz_re;
    logic             unused_nz_im;

    // Keep shifting while input is valid or until the last valid sample has left.
    assign advance = in_valid | (drain_cnt != '0);

    // Idle slots enter as zeros so stale bus values never travel down the line.
    assign ld_r = in_valid ? din_r : '0;
    assign ld_i = in_valid ? din_i : '0;

    delay_lane #(.W(WIDTH), .DEPTH(DEPTH)) u_lane_re (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .d     (ld_r),
        .q     (dout_r),
        .nz    (unused_nz_re)
    );

    delay_lane #(.W(WIDTH), .DEPTH(DEPTH)) u_lane_im (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .d     (ld_i),
        .q     (dout_i),
        .nz    (unused_nz_im)
    );

    delay_lane #(.W(1), .DEPTH(DEPTH)) u_lane_vld (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .d     (in_valid),
        .q     (out_valid),
        .nz    (valid_any)
    );

    // Phase wraps naturally because 2*DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
            phase     <= '0;
        end else begin
            if (in_valid) begin
                drain_cnt <= DCW'(DEPTH);
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DCW'(1);
            end
            if (advance) begin
                phase <= phase + CW'(1);
            end
        end
    end

    assign busy = advance | valid_any;

endmodule

// File: tb/tb_sdf_delay_line.sv
module tb_sdf_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: DEPTH=4, WIDTH=24
    logic               in_valid_a;
    logic signed [23:0] din_r_a, din_i_a, dout_r_a, dout_i_a;
    logic               out_valid_a;
    logic [2:0]         phase_a;
    logic               busy_a;

    // Instance B: DEPTH=1, WIDTH=16
    logic               in_valid_b;
    logic signed [15:0] din_r_b, din_i_b, dout_r_b, dout_i_b;
    logic               out_valid_b;
    logic [0:0]         phase_b;
    logic               busy_b;

    sdf_delay_line #(.WIDTH(24), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .din_r(din_r_a), .din_i(din_i_a),
        .dout_r(dout_r_a), .dout_i(dout_i_a), .out_valid(out_valid_a), .phase(phase_a), .busy(busy_a)
    );

    sdf_delay_line #(.WIDTH(16), .DEPTH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .din_r(din_r_b), .din_i(din_i_b),
        .dout_r(dout_r_b), .dout_i(dout_i_b), .out_valid(out_valid_b), .phase(phase_b), .busy(busy_b)
    );

    logic [52:0] got_a;
    logic [34:0] got_b;
    assign got_a = {dout_r_a, dout_i_a, out_valid_a, phase_a, busy_a};
    assign got_b = {dout_r_b, dout_i_b, out_valid_b, phase_b, busy_b};

    int checks = 0;
    int passed = 0;

    // Reference model for instance A: history of every advance slot since reset.
    typedef struct packed {
        logic        v;
        logic [23:0] r;
        logic [23:0] i;
    } ent_t;

    ent_t hist[$];
    int   drain_m = 0;
    int   adv_m   = 0;

    task automatic model_reset();
        hist.delete();
        drain_m = 0;
        adv_m   = 0;
    endtask

    task automatic model_edge(input logic iv, input logic [23:0] r, input logic [23:0] i);
        ent_t e;
        if (iv || drain_m > 0) begin
            if (iv) e = {1'b1, r, i};
            else    e = '0;
            hist.push_back(e);
            adv_m++;
        end
        if (iv)               drain_m = 4;
        else if (drain_m > 0) drain_m = drain_m - 1;
    endtask

    // Output is the slot pushed 4 advances ago; busy also sees the current in_valid.
    function automatic logic [52:0] exp_a();
        ent_t o;
        logic anyv;
        int   n;
        n    = hist.size();
        o    = '0;
        anyv = 1'b0;
        if (n >= 4) o = hist[n-4];
        for (int k = 1; k <= 4 && k <= n; k++) anyv = anyv | hist[n-k].v;
        return {o.r, o.i, o.v, 3'(adv_m % 8), in_valid_a | (drain_m > 0) | anyv};
    endfunction

    task automatic tick_a(input logic iv, input logic [23:0] r, input logic [23:0] i);
        in_valid_a = iv;
        din_r_a    = r;
        din_i_a    = i;
        @(posedge clk);
        model_edge(iv, r, i);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid_a = 1'b0; din_r_a = '0; din_i_a = '0;
        in_valid_b = 1'b0; din_r_b = '0; din_i_b = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (got_a !== 53'd0) $display("FAIL reset_a got=%h exp=0", got_a); else passed++;
        checks++; if (got_b !== 35'd0) $display("FAIL reset_b got=%h exp=0", got_b); else passed++;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            din_r_b = 16'($urandom);
            tick_a(1'b0, 24'($urandom), 24'($urandom));
            checks++; if (got_a !== 53'd0) $display("FAIL idle_a c=%0d got=%h exp=0", c, got_a); else passed++;
            checks++; if (got_b !== 35'd0) $display("FAIL idle_b c=%0d got=%h exp=0", c, got_b); else passed++;
        end
        din_r_b = '0;
    endtask

    task automatic test_latency();
        for (int s = 1; s <= 8; s++) begin
            tick_a(1'b1, 24'(s), 24'(-s));
            checks++; if (got_a !== exp_a()) $display("FAIL latency s=%0d got=%h exp=%h", s, got_a, exp_a()); else passed++;
            checks++; if (phase_a !== 3'(s)) $display("FAIL latency_phase s=%0d got=%0d exp=%0d", s, phase_a, s % 8); else passed++;
            if (s == 4) begin
                checks++;
                if (dout_r_a !== 24'sd1 || dout_i_a !== -24'sd1 || out_valid_a !== 1'b1)
                    $display("FAIL first_out got=%0d/%0d v=%b exp=1/-1 v=1", dout_r_a, dout_i_a, out_valid_a);
                else passed++;
            end
            if (s == 8) begin
                checks++; if (dout_r_a !== 24'sd5) $display("FAIL fifth_out got=%0d exp=5", dout_r_a); else passed++;
            end
        end
    endtask

    task automatic test_drain();
        for (int c = 1; c <= 6; c++) begin
            tick_a(1'b0, 24'($urandom), 24'($urandom));
            checks++; if (got_a !== exp_a()) $display("FAIL drain c=%0d got=%h exp=%h", c, got_a, exp_a()); else passed++;
            if (c <= 3) begin
                checks++;
                if (dout_r_a !== 24'(5 + c) || dout_i_a !== 24'(-(5 + c)) || out_valid_a !== 1'b1)
                    $display("FAIL drain_out c=%0d got=%0d/%0d v=%b exp=%0d", c, dout_r_a, dout_i_a, out_valid_a, 5 + c);
                else passed++;
            end else begin
                checks++;
                if (got_a !== {24'd0, 24'd0, 1'b0, 3'd4, 1'b0})
                    $display("FAIL drain_frozen c=%0d got=%h exp dout=0 v=0 phase=4 busy=0", c, got_a);
                else passed++;
            end
        end
    endtask

    task automatic test_gap();
        logic        iv_seq [10];
        logic [23:0] rs [10];
        logic [23:0] is [10];
        for (int k = 0; k < 10; k++) begin
            iv_seq[k] = (k == 0 || k == 1 || k == 4);
            rs[k] = 24'($urandom);
            is[k] = 24'($urandom);
        end
        for (int k = 0; k < 10; k++) begin
            tick_a(iv_seq[k], rs[k], is[k]);
            checks++; if (got_a !== exp_a()) $display("FAIL gap k=%0d got=%h exp=%h", k, got_a, exp_a()); else passed++;
            case (k)
                3: begin checks++; if ({out_valid_a, dout_r_a, dout_i_a} !== {1'b1, rs[0], is[0]})
                       $display("FAIL gap_A got=%h exp=%h", {out_valid_a, dout_r_a, dout_i_a}, {1'b1, rs[0], is[0]}); else passed++; end
                4: begin checks++; if ({out_valid_a, dout_r_a, dout_i_a} !== {1'b1, rs[1], is[1]})
                       $display("FAIL gap_B got=%h exp=%h", {out_valid_a, dout_r_a, dout_i_a}, {1'b1, rs[1], is[1]}); else passed++; end
                5, 6: begin checks++; if ({out_valid_a, dout_r_a, dout_i_a} !== 49'd0)
                       $display("FAIL gap_bubble k=%0d got=%h exp=0", k, {out_valid_a, dout_r_a, dout_i_a}); else passed++; end
                7: begin checks++; if ({out_valid_a, dout_r_a, dout_i_a} !== {1'b1, rs[4], is[4]})
                       $display("FAIL gap_C got=%h exp=%h", {out_valid_a, dout_r_a, dout_i_a}, {1'b1, rs[4], is[4]}); else passed++; end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 1; s <= 3; s++) begin
            tick_a(1'b1, 24'($urandom), 24'($urandom));
            checks++; if (got_a !== exp_a()) $display("FAIL mid_pre s=%0d got=%h exp=%h", s, got_a, exp_a()); else passed++;
        end
        in_valid_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (got_a !== 53'd0) $display("FAIL mid_reset got=%h exp=0", got_a); else passed++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick_a(1'b0, 24'($urandom), 24'($urandom));
            checks++; if (out_valid_a !== 1'b0 || got_a !== exp_a())
                $display("FAIL mid_after c=%0d got=%h exp=%h", c, got_a, exp_a()); else passed++;
        end
    endtask

    task automatic test_boundary_b();
        in_valid_b = 1'b1; din_r_b = 16'h8000; din_i_b = 16'h7FFF;
        @(posedge clk); @(negedge clk);
        checks++; if (dout_r_b !== -16'sd32768) $display("FAIL bnd_re got=%0d exp=-32768", dout_r_b); else passed++;
        checks++; if (dout_i_b !== 16'sd32767) $display("FAIL bnd_im got=%0d exp=32767", dout_i_b); else passed++;
        checks++; if (out_valid_b !== 1'b1 || phase_b !== 1'b1)
            $display("FAIL bnd_vld got v=%b ph=%b exp v=1 ph=1", out_valid_b, phase_b); else passed++;
        in_valid_b = 1'b0; din_r_b = 16'($urandom); din_i_b = 16'($urandom);
        @(posedge clk); @(negedge clk);
        checks++; if (got_b !== 35'd0) $display("FAIL bnd_drain got=%h exp=0", got_b); else passed++;
        @(posedge clk); @(negedge clk);
        checks++; if (got_b !== 35'd0) $display("FAIL bnd_frozen got=%h exp=0", got_b); else passed++;
    endtask

    task automatic test_random();
        logic iv;
        for (int c = 0; c < 400; c++) begin
            iv = ($urandom_range(0, 9) < 6);
            if ((c / 40) % 3 == 2) iv = 1'b0;
            tick_a(iv, 24'($urandom), 24'($urandom));
            checks++; if (got_a !== exp_a()) $display("FAIL random c=%0d got=%h exp=%h", c, got_a, exp_a()); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_drain();
        test_gap();
        test_reset_mid();
        test_boundary_b();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
